// File: rtl/mem_stage_pkg.sv
// Shared opcode constants, FSM state type and opcode decode for the MEM stage.
package mem_stage_pkg;
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_LDR = 5'd10;
  localparam logic [4:0] OP_STR = 5'd11;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  function automatic logic is_mem_op(input logic [4:0] opcode);
    return (opcode == OP_LDR) || (opcode == OP_STR);
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding memory request; expire marks the last allowed wait cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64,
  parameter int W       = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == LAST);
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack port, stalls upstream while
// a request is outstanding, and registers one result per instruction toward MEM/WB.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        OpCode,
  input  logic [6:0]        RdOut,
  input  logic [31:0]       AluResult,
  input  logic [31:0]       StoreData,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [6:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_err
);
  mem_state_t state;
  logic [6:0] rd_q;
  logic       is_mem, aligned, accept, expire;

  assign is_mem  = is_mem_op(OpCode);
  assign aligned = (AluResult[1:0] == 2'b00);
  assign accept  = (state == IDLE) && in_valid && is_mem && aligned;
  assign stall   = accept || (state == WAIT);

  // Counting stops on the completing cycle so the counter never wraps.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     ((state == WAIT) && !mem_ack && !expire),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= (OpCode == OP_STR);
            mem_addr  <= AluResult[ADDR_W+1:2];
            mem_wdata <= StoreData;
            rd_q      <= RdOut;
          end else if (in_valid) begin
            // Misaligned memory ops retire with no write and raise the sticky error.
            wb_valid <= 1'b1;
            wb_rd    <= RdOut;
            wb_we    <= !is_mem && (OpCode != OP_NOP);
            wb_data  <= is_mem ? 32'h0 : AluResult;
            if (is_mem) mem_err <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_ack || expire) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= mem_ack && !mem_we;
            wb_data  <= (mem_ack && !mem_we) ? mem_rdata : 32'h0;
            if (!mem_ack) mem_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
